// File: rtl/cpu_sequencer_if.sv
// Bundle between the sequencer and its surroundings: the decoder and ALU inputs,
// the run/step controls, and the PC, gated loads, flags and status going back out.
interface cpu_sequencer_if #(
  parameter int PC_W  = 8,
  parameter int OPC_W = 7
);
  logic [OPC_W-1:0] opcode;
  logic [7:0]       k;
  logic             la_dec;
  logic             lb_dec;
  logic             flags_we_dec;
  logic             alu_z;
  logic             alu_n;
  logic             alu_c;
  logic             alu_v;
  logic             run;
  logic             step_req;
  logic [PC_W-1:0]  pc;
  logic             la;
  logic             lb;
  logic [3:0]       flags;
  logic             step_ack;
  logic             halted;
  logic [2:0]       state;

  modport master (
    input  opcode, k, la_dec, lb_dec, flags_we_dec,
    input  alu_z, alu_n, alu_c, alu_v, run, step_req,
    output pc, la, lb, flags, step_ack, halted, state
  );

  modport slave (
    output opcode, k, la_dec, lb_dec, flags_we_dec,
    output alu_z, alu_n, alu_c, alu_v, run, step_req,
    input  pc, la, lb, flags, step_ack, halted, state
  );
endinterface

// File: rtl/cpu_sequencer.sv
// Multi-cycle control sequencer for the 8-bit accumulator CPU: owns PC and flags,
// gates register loads to one EXEC per instruction, resolves jumps, supports single-step.
module cpu_sequencer #(
  parameter int PC_W  = 8,
  parameter int OPC_W = 7
) (
  input  logic            clk,
  input  logic            rst_n,
  cpu_sequencer_if.master bus
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    EXEC  = 3'd2,
    ACK   = 3'd3,
    HALT  = 3'd4
  } state_t;

  localparam int NUM_JUMPS = 9;
  // Order: JMP, JEQ, JNE, JGT, JGE, JLT, JLE, JCR, JOV (matches cond_vec bits).
  localparam logic [6:0] JUMP_OPS [NUM_JUMPS] = '{
    7'b1001101, 7'b1001110, 7'b1001111, 7'b1010000, 7'b1010001,
    7'b1010010, 7'b1010011, 7'b1010100, 7'b1010101
  };
  localparam logic [OPC_W-1:0] OP_HLT = OPC_W'(7'b1111111);

  state_t           state_reg;
  logic [PC_W-1:0]  pc_reg;
  logic [3:0]       flags_reg;
  logic             step_mode_reg;
  logic             step_ack_reg;
  logic             halted_reg;

  logic [NUM_JUMPS-1:0] jump_match;
  logic [NUM_JUMPS-1:0] cond_vec;
  logic                 is_jump;
  logic                 is_hlt;
  logic                 jump_taken;
  logic                 in_exec;
  logic [PC_W-1:0]      next_pc;

  // Conditions are evaluated on the latched flags, never on the live ALU outputs.
  always_comb begin
    cond_vec    = '0;
    cond_vec[0] = 1'b1;
    cond_vec[1] = flags_reg[3];
    cond_vec[2] = ~flags_reg[3];
    cond_vec[3] = ~flags_reg[2] & ~flags_reg[3];
    cond_vec[4] = ~flags_reg[2];
    cond_vec[5] = flags_reg[2];
    cond_vec[6] = flags_reg[2] | flags_reg[3];
    cond_vec[7] = flags_reg[1];
    cond_vec[8] = flags_reg[0];
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_JUMPS; gi++) begin : g_jump_dec
      assign jump_match[gi] = (bus.opcode == OPC_W'(JUMP_OPS[gi]));
    end
  endgenerate

  assign is_jump    = |jump_match;
  assign is_hlt     = (bus.opcode == OP_HLT);
  assign jump_taken = |(jump_match & cond_vec);
  assign next_pc    = jump_taken ? PC_W'(bus.k) : pc_reg + PC_W'(1);
  assign in_exec    = (state_reg == EXEC);

  // Load strobes follow the decoder only inside EXEC; an async reset drops them at once.
  assign bus.la       = in_exec & bus.la_dec & ~is_jump & ~is_hlt;
  assign bus.lb       = in_exec & bus.lb_dec & ~is_jump & ~is_hlt;
  assign bus.pc       = pc_reg;
  assign bus.flags    = flags_reg;
  assign bus.step_ack = step_ack_reg;
  assign bus.halted   = halted_reg;
  assign bus.state    = state_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      pc_reg        <= '0;
      flags_reg     <= '0;
      step_mode_reg <= 1'b0;
      step_ack_reg  <= 1'b0;
      halted_reg    <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (bus.run) begin
            step_mode_reg <= 1'b0;
            state_reg     <= FETCH;
          end else if (bus.step_req) begin
            step_mode_reg <= 1'b1;
            state_reg     <= FETCH;
          end
        end
        FETCH: state_reg <= EXEC;
        EXEC: begin
          if (is_hlt) begin
            state_reg  <= HALT;
            halted_reg <= 1'b1;
          end else begin
            pc_reg <= next_pc;
            if (bus.flags_we_dec && !is_jump)
              flags_reg <= {bus.alu_z, bus.alu_n, bus.alu_c, bus.alu_v};
            // Step mode was fixed in IDLE, so a run edge mid-step is ignored here.
            if (step_mode_reg) begin
              state_reg    <= ACK;
              step_ack_reg <= 1'b1;
            end else if (bus.run) begin
              state_reg <= FETCH;
            end else begin
              state_reg <= IDLE;
            end
          end
        end
        ACK: begin
          if (!bus.step_req) begin
            step_ack_reg <= 1'b0;
            state_reg    <= IDLE;
          end
        end
        HALT: state_reg <= HALT;
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_sequencer.sv
// Bench: small instruction memory, decoder, ALU and regA/regB around the sequencer;
// an ISA-level model fills a scoreboard that is checked at every EXEC exit edge.
module tb_cpu_sequencer;

  localparam logic [6:0] OP_NOP  = 7'h00;
  localparam logic [6:0] OP_MOVA = 7'h01;
  localparam logic [6:0] OP_ADDA = 7'h02;
  localparam logic [6:0] OP_MOVB = 7'h03;
  localparam logic [6:0] OP_JMP  = 7'h4D;
  localparam logic [6:0] OP_JEQ  = 7'h4E;
  localparam logic [6:0] OP_JNE  = 7'h4F;
  localparam logic [6:0] OP_JGT  = 7'h50;
  localparam logic [6:0] OP_JGE  = 7'h51;
  localparam logic [6:0] OP_JLT  = 7'h52;
  localparam logic [6:0] OP_JLE  = 7'h53;
  localparam logic [6:0] OP_JCR  = 7'h54;
  localparam logic [6:0] OP_JOV  = 7'h55;
  localparam logic [6:0] OP_HLT  = 7'h7F;

  typedef struct packed {
    logic [7:0] pc;
    logic [3:0] flags;
    logic [7:0] a;
    logic [7:0] b;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  cpu_sequencer_if #(.PC_W(8), .OPC_W(7)) bus ();
  cpu_sequencer #(.PC_W(8), .OPC_W(7)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  logic [15:0] imem [256];
  logic [15:0] instr;
  logic [7:0]  reg_a = 8'h33;
  logic [7:0]  reg_b = 8'h00;
  logic [11:0] alu_out;
  logic [6:0]  op;
  logic        op_jump;

  int   n_checks = 0;
  int   n_errors = 0;
  int   done_cnt = 0;
  int   ack_cnt  = 0;
  logic mon_en   = 1'b0;
  exp_t sb_q[$];

  logic [7:0] m_pc;
  logic [3:0] m_flags;
  logic [7:0] m_a;
  logic [7:0] m_b;

  function automatic logic [11:0] alu_f(input logic [6:0] o, input logic [7:0] a,
                                        input logic [7:0] kk);
    logic [8:0] s;
    logic [7:0] r;
    logic       c, v;
    if (o == OP_ADDA) begin
      s = {1'b0, a} + {1'b0, kk};
      r = s[7:0];
      c = s[8];
      v = (a[7] == kk[7]) && (r[7] != a[7]);
    end else begin
      r = kk;
      c = 1'b0;
      v = 1'b0;
    end
    return {(r == 8'h00), r[7], c, v, r};
  endfunction

  function automatic logic jcond(input logic [6:0] o, input logic [3:0] f);
    case (o)
      OP_JMP:  return 1'b1;
      OP_JEQ:  return f[3];
      OP_JNE:  return !f[3];
      OP_JGT:  return !f[2] && !f[3];
      OP_JGE:  return !f[2];
      OP_JLT:  return f[2];
      OP_JLE:  return f[2] || f[3];
      OP_JCR:  return f[1];
      OP_JOV:  return f[0];
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [15:0] enc(input logic [6:0] o, input logic [7:0] kk);
    return {o, 1'b0, kk};
  endfunction

  // Decoder deliberately requests regA loads and flag writes on jumps and HLT too,
  // so any missing gating in the sequencer shows up in regA or flags.
  assign instr         = imem[bus.pc];
  assign op            = instr[15:9];
  assign op_jump       = (op >= OP_JMP) && (op <= OP_JOV);
  assign bus.opcode    = op;
  assign bus.k         = instr[7:0];
  assign bus.la_dec    = (op == OP_MOVA) || (op == OP_ADDA) || op_jump || (op == OP_HLT);
  assign bus.lb_dec    = (op == OP_MOVB);
  assign bus.flags_we_dec = (op != OP_MOVB) && (op != OP_NOP);
  assign alu_out       = alu_f(op, reg_a, instr[7:0]);
  assign bus.alu_z     = alu_out[11];
  assign bus.alu_n     = alu_out[10];
  assign bus.alu_c     = alu_out[9];
  assign bus.alu_v     = alu_out[8];

  always @(posedge clk) begin
    if (bus.la) reg_a <= alu_out[7:0];
    if (bus.lb) reg_b <= instr[7:0];
    if (bus.step_ack) ack_cnt <= ack_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_run(input int n);
    logic [6:0] o;
    logic [7:0] kk;
    logic [11:0] r;
    exp_t e;
    for (int i = 0; i < n; i++) begin
      o  = imem[m_pc][15:9];
      kk = imem[m_pc][7:0];
      if (o == OP_HLT) begin
        e = '{pc: m_pc, flags: m_flags, a: m_a, b: m_b};
        sb_q.push_back(e);
        break;
      end
      if (o >= OP_JMP && o <= OP_JOV) begin
        m_pc = jcond(o, m_flags) ? kk : m_pc + 8'd1;
      end else begin
        if (o == OP_MOVA || o == OP_ADDA) begin
          r       = alu_f(o, m_a, kk);
          m_a     = r[7:0];
          m_flags = r[11:8];
        end else if (o == OP_MOVB) begin
          m_b = kk;
        end
        m_pc = m_pc + 8'd1;
      end
      e = '{pc: m_pc, flags: m_flags, a: m_a, b: m_b};
      sb_q.push_back(e);
    end
  endtask

  task automatic clear_imem();
    for (int i = 0; i < 256; i++) imem[i] = enc(OP_HLT, 8'h00);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n        = 1'b0;
    bus.run      = 1'b0;
    bus.step_req = 1'b0;
    repeat (2) @(negedge clk);
    rst_n   = 1'b1;
    m_pc    = 8'h00;
    m_flags = 4'h0;
  endtask

  task automatic wait_state(input logic [2:0] s, input int max_cyc, input string tag);
    logic found;
    found = 1'b0;
    for (int i = 0; i < max_cyc && !found; i++) begin
      @(negedge clk);
      if (bus.state == s) found = 1'b1;
    end
    if (!found) chk(tag, {29'd0, bus.state}, {29'd0, s});
  endtask

  // Scoreboard monitor: every completed EXEC pops one expected result.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (mon_en && rst_n && bus.state == 3'd2) begin
        @(posedge clk);
        #1;
        if (rst_n) begin
          done_cnt++;
          if (sb_q.size() == 0) begin
            chk("sb_underflow", 32'd1, 32'd0);
          end else begin
            e = sb_q.pop_front();
            $display("instr done: pc=%02h flags=%h a=%02h b=%02h", bus.pc, bus.flags, reg_a, reg_b);
            chk("sb_pc", bus.pc, e.pc);
            chk("sb_flags", bus.flags, e.flags);
            chk("sb_rega", reg_a, e.a);
            chk("sb_regb", reg_b, e.b);
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int done_base, ack_base;
    bus.run      = 1'b0;
    bus.step_req = 1'b0;
    m_a = 8'h33;
    m_b = 8'h00;
    clear_imem();
    imem[0] = enc(OP_MOVA, 8'h5A);

    // Reset state, then async reset in the middle of EXEC.
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    m_pc = 8'h00; m_flags = 4'h0;
    @(negedge clk);
    chk("rst_pc", bus.pc, 0);
    chk("rst_flags", bus.flags, 0);
    chk("rst_state", bus.state, 0);
    chk("rst_la_lb", {bus.la, bus.lb}, 0);
    chk("rst_ack", bus.step_ack, 0);
    chk("rst_halted", bus.halted, 0);
    bus.run = 1'b1;
    @(negedge clk);
    chk("run_fetch_state", bus.state, 1);
    chk("run_fetch_la", bus.la, 0);
    @(negedge clk);
    chk("run_exec_state", bus.state, 2);
    chk("run_exec_la", bus.la, 1);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_la", bus.la, 0);
    chk("rst_mid_state", bus.state, 0);
    bus.run = 1'b0;
    @(posedge clk);
    #1;
    chk("rst_mid_rega", reg_a, 8'h33);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_rel_pc", bus.pc, 0);
    chk("rst_rel_state", bus.state, 0);
    mon_en = 1'b1;

    // Free-run straight line ending in HLT.
    clear_imem();
    imem[0] = enc(OP_MOVA, 8'h05);
    imem[1] = enc(OP_ADDA, 8'h03);
    imem[2] = enc(OP_HLT, 8'h00);
    model_run(10);
    bus.run = 1'b1;
    wait_state(3'd4, 40, "line_halt_timeout");
    chk("line_halted", bus.halted, 1);
    chk("line_rega", reg_a, 8'h08);
    repeat (5) @(negedge clk);
    chk("line_pc_hold", bus.pc, 2);
    chk("line_state_hold", bus.state, 4);
    chk("line_sb_empty", sb_q.size(), 0);
    do_reset();

    // Conditional jumps over every condition, with taken and not-taken cases.
    clear_imem();
    imem[8'h00] = enc(OP_MOVA, 8'h00);
    imem[8'h01] = enc(OP_JEQ, 8'h10);
    imem[8'h10] = enc(OP_MOVA, 8'h01);
    imem[8'h11] = enc(OP_JEQ, 8'h20);
    imem[8'h12] = enc(OP_JNE, 8'h30);
    imem[8'h30] = enc(OP_MOVA, 8'h80);
    imem[8'h31] = enc(OP_JLT, 8'h40);
    imem[8'h40] = enc(OP_ADDA, 8'h80);
    imem[8'h41] = enc(OP_JCR, 8'h50);
    imem[8'h50] = enc(OP_JGT, 8'h60);
    imem[8'h51] = enc(OP_JLE, 8'h58);
    imem[8'h58] = enc(OP_MOVB, 8'h77);
    imem[8'h59] = enc(OP_JOV, 8'h70);
    imem[8'h70] = enc(OP_JGE, 8'h74);
    imem[8'h74] = enc(OP_JMP, 8'h78);
    imem[8'h78] = enc(OP_HLT, 8'h00);
    model_run(40);
    bus.run = 1'b1;
    wait_state(3'd4, 200, "jump_halt_timeout");
    chk("jump_pc", bus.pc, 8'h78);
    chk("jump_flags", bus.flags, 4'b1011);
    chk("jump_regb", reg_b, 8'h77);
    chk("jump_sb_empty", sb_q.size(), 0);
    do_reset();

    // PC wrap-around from 0xFF.
    clear_imem();
    imem[8'h00] = enc(OP_JNE, 8'hFF);
    imem[8'hFF] = enc(OP_MOVA, 8'h00);
    imem[8'h01] = enc(OP_HLT, 8'h00);
    model_run(10);
    bus.run = 1'b1;
    wait_state(3'd4, 40, "wrap_halt_timeout");
    chk("wrap_pc", bus.pc, 8'h01);
    chk("wrap_sb_empty", sb_q.size(), 0);
    do_reset();

    // Single-step with a held request.
    clear_imem();
    imem[0] = enc(OP_MOVA, 8'h11);
    imem[1] = enc(OP_ADDA, 8'h22);
    model_run(1);
    bus.step_req = 1'b1;
    @(negedge clk);
    chk("step_fetch_ack", bus.step_ack, 0);
    @(negedge clk);
    chk("step_exec_ack", bus.step_ack, 0);
    @(negedge clk);
    chk("step_ack_rise", bus.step_ack, 1);
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      chk("step_ack_hold", bus.step_ack, 1);
      chk("step_pc_hold", bus.pc, 1);
    end
    bus.step_req = 1'b0;
    @(negedge clk);
    chk("step_ack_fall", bus.step_ack, 0);
    chk("step_idle", bus.state, 0);
    repeat (3) @(negedge clk);
    chk("step_pc_idle", bus.pc, 1);
    model_run(1);
    bus.step_req = 1'b1;
    @(negedge clk);
    bus.run = 1'b1;
    wait_state(3'd3, 10, "step2_ack_timeout");
    chk("step2_state", bus.state, 3);
    chk("step2_pc", bus.pc, 2);
    chk("step2_rega", reg_a, 8'h33);
    bus.run = 1'b0;
    bus.step_req = 1'b0;
    @(negedge clk);
    chk("step2_idle", bus.state, 0);
    chk("step_sb_empty", sb_q.size(), 0);
    do_reset();

    // run and step_req together: free-run wins; run dropped mid-EXEC ends in IDLE.
    clear_imem();
    imem[0] = enc(OP_MOVA, 8'h01);
    imem[1] = enc(OP_MOVA, 8'h02);
    imem[2] = enc(OP_MOVA, 8'h03);
    imem[3] = enc(OP_MOVA, 8'h04);
    model_run(3);
    done_base = done_cnt;
    ack_base  = ack_cnt;
    bus.run = 1'b1;
    bus.step_req = 1'b1;
    begin
      logic found;
      found = 1'b0;
      for (int i = 0; i < 30 && !found; i++) begin
        @(negedge clk);
        if (done_cnt == done_base + 2 && bus.state == 3'd2) found = 1'b1;
      end
      if (!found) chk("both_exec_timeout", 32'd0, 32'd1);
    end
    bus.run = 1'b0;
    bus.step_req = 1'b0;
    @(negedge clk);
    chk("both_idle", bus.state, 0);
    chk("both_pc", bus.pc, 3);
    chk("both_rega", reg_a, 8'h03);
    chk("both_done", done_cnt - done_base, 3);
    chk("both_no_ack", ack_cnt - ack_base, 0);
    chk("both_sb_empty", sb_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
